arilla_bus_arbiter: RTL and testbench

- Shares the single arilla system bus (one slave port into memory/peripherals) between several bus masters: core instruction fetch, core data port and the debug module.
- Grants one requester at a time and holds the grant until the slave reports completion.
- Uses a high-priority class (debug) plus round-robin inside each class.
- A watchdog releases the bus and flags an error if a granted transfer never completes.

---
 rtl/arilla_bus_pkg.sv | 16 +
 rtl/arilla_bus_arbiter_if.sv | 28 ++
 rtl/arilla_bus_arbiter_picker.sv | 32 +++
 rtl/arilla_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_arilla_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arilla_bus_pkg.sv
// Shared arilla system-bus definitions: arbiter FSM states and index-width helper.
package arilla_bus_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int DefaultNumRequesters = 3;

    // A single requester still needs one index bit so the port never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arilla_bus_arbiter_if.sv
// Request/grant bundle between the bus masters (master side) and the arbiter (slave side).
interface arilla_bus_arbiter_if
    import arilla_bus_pkg::*;
#(
    parameter int NumRequesters = DefaultNumRequesters,
    parameter int TimeoutWidth  = 8
);
    localparam int IdxW = idx_width(NumRequesters);

    logic [NumRequesters-1:0] req;
    logic                     done;
    logic [NumRequesters-1:0] grant;
    logic                     grant_valid;
    logic [IdxW-1:0]          grant_index;
    logic                     timeout;
    logic [TimeoutWidth-1:0]  busy_cycles;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_index, timeout, busy_cycles
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_index, timeout, busy_cycles
    );

endinterface

// File: rtl/arilla_bus_arbiter_picker.sv
// Combinational round-robin picker: first set candidate after rr_ptr, wrapping.
module rr_priority_picker
    import arilla_bus_pkg::*;
#(
    parameter int  NumRequesters = DefaultNumRequesters,
    localparam int IdxW          = idx_width(NumRequesters)
) (
    input  logic [NumRequesters-1:0] cand,
    input  logic [IdxW-1:0]          rr_ptr,
    output logic [NumRequesters-1:0] winner,
    output logic [IdxW-1:0]          win_idx,
    output logic                     found
);

    int pos;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int off = 1; off <= NumRequesters; off++) begin
            pos = (int'(rr_ptr) + off) % NumRequesters;
            if (!found && cand[IdxW'(pos)]) begin
                found               = 1'b1;
                winner[IdxW'(pos)]  = 1'b1;
                win_idx             = IdxW'(pos);
            end
        end
    end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Arilla system-bus arbiter: debug-priority class, round-robin within class,
// grant held until done, watchdog release on stuck transfers.
module arilla_bus_arbiter
    import arilla_bus_pkg::*;
#(
    parameter int                       NumRequesters = DefaultNumRequesters,
    parameter logic [NumRequesters-1:0] PriorityMask  = 3'b100,
    parameter int                       TimeoutCycles = 255,
    parameter int                       TimeoutWidth  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    arilla_bus_arbiter_if.slave bus
);

    localparam int                      IdxW        = idx_width(NumRequesters);
    localparam bit                      WdogEn      = (TimeoutCycles != 0);
    localparam logic [TimeoutWidth-1:0] ExpireCount = TimeoutWidth'(TimeoutCycles - 1);
    localparam logic [TimeoutWidth-1:0] BusyMax     = '1;

    arb_state_e               state_q, state_d;
    logic [NumRequesters-1:0] grant_q, grant_d;
    logic [NumRequesters-1:0] blocked_q, blocked_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [IdxW-1:0]          rr_q, rr_d;
    logic [TimeoutWidth-1:0]  busy_q, busy_d;
    logic                     timeout_q, timeout_d;

    logic [NumRequesters-1:0] elig, cand, win_onehot;
    logic [IdxW-1:0]          win_idx;
    logic                     win_found, owner_req, expire;

    // The current owner is masked out so a done cycle can hand straight over to someone else;
    // a timed-out master stays masked until it has dropped req for a cycle.
    assign elig      = bus.req & ~blocked_q & ~grant_q;
    assign cand      = (|(elig & PriorityMask)) ? (elig & PriorityMask) : elig;
    assign owner_req = |(bus.req & grant_q);
    assign expire    = WdogEn && (busy_q == ExpireCount);

    rr_priority_picker #(
        .NumRequesters(NumRequesters)
    ) u_picker (
        .cand   (cand),
        .rr_ptr (rr_q),
        .winner (win_onehot),
        .win_idx(win_idx),
        .found  (win_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            rr_q      <= IdxW'(NumRequesters - 1);
            busy_q    <= '0;
            timeout_q <= 1'b0;
            blocked_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            blocked_q <= blocked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        blocked_d = blocked_q & bus.req;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OWNED;
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    rr_d    = win_idx;
                    busy_d  = '0;
                end
            end
            OWNED: begin
                // done outranks abandon, and abandon outranks watchdog expiry.
                if (bus.done && win_found) begin
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    rr_d    = win_idx;
                    busy_d  = '0;
                end else if (bus.done || !owner_req || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    busy_d  = '0;
                    if (!bus.done && owner_req) begin
                        timeout_d = 1'b1;
                        blocked_d = blocked_d | grant_q;
                    end
                end else if (busy_q != BusyMax) begin
                    busy_d = busy_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                busy_d  = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_index = idx_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy_cycles = busy_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter: two instances (TimeoutCycles 255 and 4) share stimulus
// and are each compared every cycle against an owner/pointer level reference model.
module tb_arilla_bus_arbiter;
    import arilla_bus_pkg::*;

    localparam bit [2:0] PMASK = 3'b100;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state per instance: owner index (-1 idle), rr pointer, busy count.
    int       m_owner [2];
    int       m_rr    [2];
    int       m_busy  [2];
    bit       m_to    [2];
    bit [2:0] m_blk   [2];

    arilla_bus_arbiter_if #(.NumRequesters(3), .TimeoutWidth(8)) bus_a ();
    arilla_bus_arbiter_if #(.NumRequesters(3), .TimeoutWidth(8)) bus_b ();

    assign bus_a.req  = req;
    assign bus_a.done = done;
    assign bus_b.req  = req;
    assign bus_b.done = done;

    arilla_bus_arbiter #(
        .NumRequesters(3), .PriorityMask(3'b100), .TimeoutCycles(255), .TimeoutWidth(8)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    arilla_bus_arbiter #(
        .NumRequesters(3), .PriorityMask(3'b100), .TimeoutCycles(4), .TimeoutWidth(8)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit [2:0] elig, input int rr);
        bit [2:0] c;
        int i;
        c = elig;
        if ((elig & PMASK) != 3'b000) c = elig & PMASK;
        for (int k = 1; k <= 3; k++) begin
            i = (rr + k) % 3;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int n);
        m_owner[n] = -1;
        m_rr[n]    = 2;
        m_busy[n]  = 0;
        m_to[n]    = 1'b0;
        m_blk[n]   = 3'b000;
    endtask

    task automatic model_step(input int n);
        bit [2:0] nb;
        bit [2:0] own;
        int w;
        int tmo;
        tmo   = (n == 0) ? 255 : 4;
        nb    = m_blk[n] & req;
        m_to[n] = 1'b0;
        own   = (m_owner[n] < 0) ? 3'b000 : 3'(1 << m_owner[n]);
        if (m_owner[n] < 0) begin
            w = pick(req & ~m_blk[n], m_rr[n]);
            if (w >= 0) begin
                m_owner[n] = w; m_rr[n] = w; m_busy[n] = 0;
            end
        end else if (done) begin
            w = pick(req & ~m_blk[n] & ~own, m_rr[n]);
            if (w >= 0) begin
                m_owner[n] = w; m_rr[n] = w;
            end else begin
                m_owner[n] = -1;
            end
            m_busy[n] = 0;
        end else if (!req[m_owner[n]]) begin
            m_owner[n] = -1; m_busy[n] = 0;
        end else if (m_busy[n] == tmo - 1) begin
            m_to[n] = 1'b1;
            nb = nb | own;
            m_owner[n] = -1; m_busy[n] = 0;
        end else if (m_busy[n] < 255) begin
            m_busy[n]++;
        end
        m_blk[n] = nb;
    endtask

    task automatic cmp_inst(input string nm, input int n, input logic [2:0] g, input logic gv,
                            input logic [1:0] gi, input logic to, input logic [7:0] bc);
        logic [2:0] eg;
        eg = (m_owner[n] < 0) ? 3'b000 : 3'(1 << m_owner[n]);
        check_val({nm, ".grant"},       {29'd0, g},  {29'd0, eg});
        check_val({nm, ".grant_valid"}, {31'd0, gv}, {31'd0, (m_owner[n] >= 0)});
        check_val({nm, ".grant_index"}, {30'd0, gi}, (m_owner[n] < 0) ? 32'd0 : 32'(m_owner[n]));
        check_val({nm, ".timeout"},     {31'd0, to}, {31'd0, m_to[n]});
        check_val({nm, ".busy_cycles"}, {24'd0, bc}, 32'(m_busy[n]));
    endtask

    task automatic check_all();
        cmp_inst("a", 0, bus_a.grant, bus_a.grant_valid, bus_a.grant_index, bus_a.timeout, bus_a.busy_cycles);
        cmp_inst("b", 1, bus_b.grant, bus_b.grant_valid, bus_b.grant_index, bus_b.timeout, bus_b.busy_cycles);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) model_reset(n);
            else        model_step(n);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b111;
        done  = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check_all();

        // Debug master wins first after reset release.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t1.grant", {29'd0, bus_a.grant}, 32'h4);
        check_val("t1.index", {30'd0, bus_a.grant_index}, 32'd2);

        // Core masters alternate on done with no idle cycle in between.
        req = 3'b000;
        do_reset();
        req = 3'b011;
        for (int c = 0; c < 12; c++) begin
            done = (c % 4 == 3);
            tick();
            if (c == 3) check_val("t2.handover1", {29'd0, bus_a.grant}, 32'h2);
            if (c == 7) check_val("t2.handover2", {29'd0, bus_a.grant}, 32'h1);
            if (c >= 1) check_val("t2.no_bubble", {31'd0, bus_a.grant_valid}, 32'd1);
        end
        done = 1'b0;

        // No preemption by the debug master; it takes over on done.
        req = 3'b000;
        do_reset();
        req = 3'b001;
        tick();
        tick();
        req = 3'b101;
        tick();
        tick();
        check_val("t3.held", {29'd0, bus_a.grant}, 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("t3.next_a", {29'd0, bus_a.grant}, 32'h4);
        check_val("t3.next_b", {29'd0, bus_b.grant}, 32'h4);

        // Watchdog expiry and blocking of the timed-out master.
        req = 3'b000;
        do_reset();
        req = 3'b001;
        for (int c = 0; c < 4; c++) tick();
        check_val("t4.pre_to", {31'd0, bus_b.timeout}, 32'd0);
        tick();
        check_val("t4.timeout", {31'd0, bus_b.timeout}, 32'd1);
        check_val("t4.release", {29'd0, bus_b.grant}, 32'h0);
        for (int c = 0; c < 3; c++) tick();
        check_val("t4.blocked", {29'd0, bus_b.grant}, 32'h0);
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        check_val("t4.regrant", {29'd0, bus_b.grant}, 32'h1);

        // done coinciding with expiry wins.
        req = 3'b000;
        do_reset();
        req = 3'b001;
        for (int c = 0; c < 4; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("t5.no_timeout", {31'd0, bus_b.timeout}, 32'd0);
        check_val("t5.release", {29'd0, bus_b.grant}, 32'h0);

        // Asynchronous reset mid-transfer.
        req = 3'b000;
        do_reset();
        req = 3'b011;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("t6.owner1", {29'd0, bus_a.grant}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6.async_grant_a", {29'd0, bus_a.grant}, 32'h0);
        check_val("t6.async_busy_a", {24'd0, bus_a.busy_cycles}, 32'd0);
        check_val("t6.async_grant_b", {29'd0, bus_b.grant}, 32'h0);
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t6.first_after", {29'd0, bus_a.grant}, 32'h1);

        // Randomized traffic, including abandons, idle done pulses and occasional resets.
        req  = 3'b000;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(399) == 0) begin
                rst_n = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (m_owner[0] == i) req[i] = ($urandom_range(15) != 0);
                else if ($urandom_range(3) == 0) req[i] = ~req[i];
            end
            if (m_owner[0] >= 0 || m_owner[1] >= 0) done = ($urandom_range(5) == 0);
            else done = ($urandom_range(19) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
